// File: rtl/spi_pkg.sv
// Shared definitions for the SPI data-memory link: field widths, rw encoding,
// controller state encoding and the frame builder.
package spi_pkg;

    localparam int SPI_ADDR_W  = 7;
    localparam int SPI_DATA_W  = 8;
    localparam int SPI_FRAME_W = 16;

    localparam logic SPI_READ  = 1'b1;
    localparam logic SPI_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } ctrl_state_t;

    // Reads carry an all-zero data field so mosi stays low while the slave answers.
    function automatic logic [SPI_FRAME_W-1:0] build_frame(
        input logic [SPI_ADDR_W-1:0] addr,
        input logic                  rw,
        input logic [SPI_DATA_W-1:0] wdata
    );
        logic [SPI_DATA_W-1:0] data;
        data = (rw == SPI_READ) ? {SPI_DATA_W{1'b0}} : wdata;
        return {addr, rw, data};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator for sclk. tick fires every CLK_DIV enabled cycles;
// rise/fall tell whether that tick raises or lowers sclk (phase restarts low on clr).
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             phase;

    assign tick = en && (div_cnt == '0);
    assign rise = tick && !phase;
    assign fall = tick && phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (clr) begin
            div_cnt <= RELOAD;
            phase   <= 1'b0;
        end else if (en) begin
            if (div_cnt == '0) begin
                div_cnt <= RELOAD;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master for the data-memory peripheral: one 16-bit frame
// {addr, rw, data} per accepted request, read byte or write completion returned on rsp_valid.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rw,
    input  logic [SPI_ADDR_W-1:0] req_addr,
    input  logic [SPI_DATA_W-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [SPI_DATA_W-1:0] rsp_rdata,
    output logic                  busy,
    output logic                  cs,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);

    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    ctrl_state_t            state, state_n;
    logic                   cs_q, cs_n;
    logic                   sclk_q, sclk_n;
    logic [SPI_FRAME_W-1:0] frame_q, frame_n;
    logic [SPI_DATA_W-1:0]  rx_q, rx_n;
    logic [3:0]             bit_cnt, bit_cnt_n;
    logic                   last_bit, last_bit_n;
    logic [7:0]             gap_cnt, gap_cnt_n;
    logic                   rsp_valid_q, rsp_valid_n;
    logic [SPI_DATA_W-1:0]  rsp_rdata_q, rsp_rdata_n;
    logic                   rw_q, rw_n;

    logic div_en, div_clr, div_tick, div_rise, div_fall;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (div_clr),
        .tick  (div_tick),
        .rise  (div_rise),
        .fall  (div_fall)
    );

    // Request handshake: a request transfers on a rising clk edge where
    // req_valid && req_ready; req_ready is high exactly while the FSM is in IDLE.
    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign cs        = cs_q;
    assign sclk      = sclk_q;
    assign mosi      = frame_q[SPI_FRAME_W-1];
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    always_comb begin
        state_n     = state;
        cs_n        = cs_q;
        sclk_n      = sclk_q;
        frame_n     = frame_q;
        rx_n        = rx_q;
        bit_cnt_n   = bit_cnt;
        last_bit_n  = last_bit;
        gap_cnt_n   = gap_cnt;
        rsp_valid_n = 1'b0;
        rsp_rdata_n = rsp_rdata_q;
        rw_n        = rw_q;
        div_en      = 1'b0;
        div_clr     = 1'b0;

        unique case (state)
            IDLE: begin
                div_clr = 1'b1;
                if (req_valid) begin
                    state_n    = SETUP;
                    cs_n       = 1'b0;
                    sclk_n     = 1'b0;
                    frame_n    = build_frame(req_addr, req_rw, req_wdata);
                    rw_n       = req_rw;
                    rx_n       = '0;
                    bit_cnt_n  = '0;
                    last_bit_n = 1'b0;
                end
            end
            SETUP: begin
                div_en = 1'b1;
                if (div_rise) state_n = SHIFT;
            end
            SHIFT: begin
                div_en = 1'b1;
                if (div_fall && last_bit) begin
                    state_n = HOLD;
                    frame_n = '0;
                end
            end
            HOLD: begin
                div_en = 1'b1;
                if (div_tick) begin
                    state_n     = GAP;
                    cs_n        = 1'b1;
                    rsp_valid_n = 1'b1;
                    rsp_rdata_n = (rw_q == SPI_WRITE) ? '0 : rx_q;
                    gap_cnt_n   = GAP_RELOAD;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_n = IDLE;
                else               gap_cnt_n = gap_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase

        // Rising sclk: slave samples mosi, we sample miso on read data bits.
        // bit_cnt saturates at 15 and last_bit marks the 16th rise.
        if ((state == SETUP || state == SHIFT) && div_rise) begin
            sclk_n = 1'b1;
            if (rw_q == SPI_READ && bit_cnt[3]) rx_n = {rx_q[SPI_DATA_W-2:0], miso};
            if (bit_cnt == 4'd15) last_bit_n = 1'b1;
            else                  bit_cnt_n  = bit_cnt + 1'b1;
        end

        if (state == SHIFT && div_fall) begin
            sclk_n = 1'b0;
            if (!last_bit) frame_n = {frame_q[SPI_FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            frame_q     <= '0;
            rx_q        <= '0;
            bit_cnt     <= '0;
            last_bit    <= 1'b0;
            gap_cnt     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rw_q        <= 1'b0;
        end else begin
            state       <= state_n;
            cs_q        <= cs_n;
            sclk_q      <= sclk_n;
            frame_q     <= frame_n;
            rx_q        <= rx_n;
            bit_cnt     <= bit_cnt_n;
            last_bit    <= last_bit_n;
            gap_cnt     <= gap_cnt_n;
            rsp_valid_q <= rsp_valid_n;
            rsp_rdata_q <= rsp_rdata_n;
            rw_q        <= rw_n;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: default-parameter instance against a slave +
// data-memory model, plus a CLK_DIV=2 / CS_GAP=1 instance for the fast timing case.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       busy, cs, sclk, mosi;
    logic       miso = 1'b0;

    logic       req_valid_b, req_ready_b, req_rw_b;
    logic [6:0] req_addr_b;
    logic [7:0] req_wdata_b;
    logic       rsp_valid_b;
    logic [7:0] rsp_rdata_b;
    logic       busy_b, cs_b, sclk_b, mosi_b;
    logic       miso_b = 1'b1;

    spi_master_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    spi_master_ctrl #(.CLK_DIV(2), .CS_GAP(1)) dut_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_rw(req_rw_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .busy(busy_b),
        .cs(cs_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Slave + data-memory model: shifts mosi on rising sclk, answers reads on falling sclk.
    logic [7:0]  mem [0:127];
    int          s_cnt = 0;
    logic [15:0] s_sh  = '0;
    logic [6:0]  s_addr = '0;
    logic        s_rw  = 1'b0;
    logic [7:0]  s_tmp;

    always @(posedge sclk or posedge cs) begin
        if (cs) begin
            s_cnt = 0;
        end else begin
            s_sh  = {s_sh[14:0], mosi};
            s_cnt = s_cnt + 1;
            if (s_cnt == 8) begin
                s_addr = s_sh[7:1];
                s_rw   = s_sh[0];
            end
            if (s_cnt == 16 && !s_rw) mem[s_addr] = s_sh[7:0];
        end
    end

    always @(negedge sclk or posedge cs) begin
        if (!cs && s_rw && s_cnt >= 8 && s_cnt < 16) begin
            s_tmp = mem[s_addr];
            miso  = s_tmp[15 - s_cnt];
        end else begin
            miso = 1'($urandom_range(0, 1));
        end
    end

    // Results of observe(); rel cycle 1 is the first cycle after the accept edge.
    int          first_low, last_low, low_cnt, rsp_rel, rsp_cnt, ready_rel;
    int          busy_low_rel, rise_cnt, first_rise;
    logic [7:0]  rsp_data;
    logic [15:0] mosi_bits;

    task automatic issue(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                         input bit hold, output int k);
        @(negedge clk);
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        k = -1;
        for (int i = 0; i < 400 && k < 0; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                k = cyc;
                if (!hold) req_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (k < 0) $display("FAIL accept_timeout got no accept exp accept within 400 cycles");
        else       n_pass++;
    endtask

    task automatic observe(input int k, input int max_cyc);
        int   rel;
        logic prev;
        first_low = 0; last_low = 0; low_cnt = 0; rsp_rel = 0; rsp_cnt = 0;
        ready_rel = 0; busy_low_rel = 0; rise_cnt = 0; first_rise = 0;
        rsp_data = '0; mosi_bits = '0;
        prev = sclk;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            rel = cyc - k + 1;
            if (!cs) begin
                low_cnt++;
                if (first_low == 0) first_low = rel;
                last_low = rel;
            end
            if (sclk && !prev) begin
                rise_cnt++;
                if (first_rise == 0) first_rise = rel;
                if (rise_cnt <= 16) mosi_bits = {mosi_bits[14:0], mosi};
            end
            prev = sclk;
            if (rsp_valid) begin
                rsp_cnt++;
                rsp_rel  = rel;
                rsp_data = rsp_rdata;
            end
            if (!busy && busy_low_rel == 0) busy_low_rel = rel;
            if (req_ready) begin
                ready_rel = rel;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_rw = 1'b0; req_addr = '0; req_wdata = '0;
        req_valid_b = 1'b0; req_rw_b = 1'b0; req_addr_b = '0; req_wdata_b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if ({cs, sclk, mosi} !== 3'b100) $display("FAIL rst_pins got %b exp 100", {cs, sclk, mosi}); else n_pass++;
        n_checks++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {rsp_valid, busy}); else n_pass++;
        n_checks++; if (rsp_rdata !== 8'h00) $display("FAIL rst_rdata got %h exp 00", rsp_rdata); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b exp 1", req_ready); else n_pass++;
    endtask

    task automatic test_write_frame();
        int k;
        issue(1'b0, 7'h2A, 8'hC3, 1'b0, k);
        observe(k, 300);
        n_checks++; if (first_low !== 1)   $display("FAIL wr_cs_fall got %0d exp 1", first_low); else n_pass++;
        n_checks++; if (last_low !== 132)  $display("FAIL wr_cs_last_low got %0d exp 132", last_low); else n_pass++;
        n_checks++; if (low_cnt !== 132)   $display("FAIL wr_cs_low_cnt got %0d exp 132", low_cnt); else n_pass++;
        n_checks++; if (first_rise !== 5)  $display("FAIL wr_first_rise got %0d exp 5", first_rise); else n_pass++;
        n_checks++; if (rise_cnt !== 16)   $display("FAIL wr_rises got %0d exp 16", rise_cnt); else n_pass++;
        n_checks++; if (mosi_bits !== 16'h54C3) $display("FAIL wr_mosi got %h exp 54c3", mosi_bits); else n_pass++;
        n_checks++; if (rsp_rel !== 133)   $display("FAIL wr_rsp_cycle got %0d exp 133", rsp_rel); else n_pass++;
        n_checks++; if (rsp_cnt !== 1)     $display("FAIL wr_rsp_cnt got %0d exp 1", rsp_cnt); else n_pass++;
        n_checks++; if (rsp_data !== 8'h00) $display("FAIL wr_rdata got %h exp 00", rsp_data); else n_pass++;
        n_checks++; if (ready_rel !== 137) $display("FAIL wr_ready_cycle got %0d exp 137", ready_rel); else n_pass++;
        n_checks++; if (mem[7'h2A] !== 8'hC3) $display("FAIL wr_mem got %h exp c3", mem[7'h2A]); else n_pass++;
    endtask

    task automatic test_read_frame();
        int k;
        mem[7'h05] = 8'hA5;
        issue(1'b1, 7'h05, 8'hFF, 1'b0, k);
        observe(k, 300);
        n_checks++; if (mosi_bits !== 16'h0B00) $display("FAIL rd_mosi got %h exp 0b00", mosi_bits); else n_pass++;
        n_checks++; if (rsp_rel !== 133)   $display("FAIL rd_rsp_cycle got %0d exp 133", rsp_rel); else n_pass++;
        n_checks++; if (rsp_data !== 8'hA5) $display("FAIL rd_rdata got %h exp a5", rsp_data); else n_pass++;
        n_checks++; if (busy_low_rel !== 137) $display("FAIL rd_busy_low got %0d exp 137", busy_low_rel); else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++; if (rsp_rdata !== 8'hA5) $display("FAIL rd_rdata_hold got %h exp a5", rsp_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int         k, phase, gap, nr, viol;
        bit         acc2;
        logic [7:0] rd [2];
        mem[7'h10] = 8'h00;
        issue(1'b0, 7'h10, 8'h7E, 1'b1, k);
        req_rw = 1'b1; req_addr = 7'h10; req_wdata = 8'hFF;
        phase = 0; gap = 0; nr = 0; viol = 0; acc2 = 1'b0;
        rd[0] = 8'hXX; rd[1] = 8'hXX;
        for (int i = 0; i < 700 && nr < 2; i++) begin
            @(negedge clk);
            if (!cs && req_ready) viol++;
            if (rsp_valid) begin
                if (nr < 2) rd[nr] = rsp_rdata;
                nr++;
            end
            case (phase)
                0: if (cs) begin phase = 1; gap = 1; end
                1: if (cs) gap++; else phase = 2;
                default: ;
            endcase
            if (req_ready && !acc2 && phase == 1) begin
                @(posedge clk);
                #1;
                req_valid = 1'b0;
                acc2 = 1'b1;
            end
        end
        n_checks++; if (gap !== 5)        $display("FAIL b2b_cs_gap got %0d exp 5", gap); else n_pass++;
        n_checks++; if (nr !== 2)         $display("FAIL b2b_rsp_cnt got %0d exp 2", nr); else n_pass++;
        n_checks++; if (rd[0] !== 8'h00)  $display("FAIL b2b_wr_rdata got %h exp 00", rd[0]); else n_pass++;
        n_checks++; if (rd[1] !== 8'h7E)  $display("FAIL b2b_rd_rdata got %h exp 7e", rd[1]); else n_pass++;
        n_checks++; if (viol !== 0)       $display("FAIL b2b_ready_in_frame got %0d exp 0", viol); else n_pass++;
    endtask

    task automatic test_hold_fields();
        int k1, k2, viol;
        mem[7'h33] = 8'h00;
        mem[7'h44] = 8'h00;
        issue(1'b0, 7'h33, 8'h11, 1'b1, k1);
        viol = 0; k2 = -1;
        for (int i = 0; i < 400 && k2 < 0; i++) begin
            @(negedge clk);
            if (req_ready) begin
                req_rw = 1'b0; req_addr = 7'h44; req_wdata = 8'h5A;
                @(posedge clk);
                #1;
                k2 = cyc;
                req_valid = 1'b0; req_rw = 1'b1; req_addr = 7'h7F; req_wdata = 8'h00;
            end else begin
                if (busy !== 1'b1) viol++;
                req_rw    = 1'($urandom_range(0, 1));
                req_addr  = 7'($urandom_range(0, 127));
                req_wdata = 8'($urandom_range(0, 255));
            end
        end
        n_checks++; if (k2 - k1 !== 137) $display("FAIL hold_accept_spacing got %0d exp 137", k2 - k1); else n_pass++;
        n_checks++; if (viol !== 0)      $display("FAIL hold_busy got %0d exp 0", viol); else n_pass++;
        observe(k2, 300);
        n_checks++; if (mosi_bits !== 16'h885A) $display("FAIL hold_mosi got %h exp 885a", mosi_bits); else n_pass++;
        n_checks++; if (mem[7'h33] !== 8'h11) $display("FAIL hold_first_mem got %h exp 11", mem[7'h33]); else n_pass++;
        n_checks++; if (mem[7'h44] !== 8'h5A) $display("FAIL hold_second_mem got %h exp 5a", mem[7'h44]); else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int   k, rises, nr, lowc;
        logic prev;
        issue(1'b1, 7'h10, 8'h00, 1'b0, k);
        rises = 0; prev = sclk;
        for (int i = 0; i < 300 && rises < 9; i++) begin
            @(negedge clk);
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        n_checks++; if (rises !== 9) $display("FAIL mid_rises got %0d exp 9", rises); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({cs, sclk, mosi} !== 3'b100) $display("FAIL mid_rst_pins got %b exp 100", {cs, sclk, mosi}); else n_pass++;
        n_checks++; if ({busy, rsp_valid, req_ready} !== 3'b001) $display("FAIL mid_rst_flags got %b exp 001", {busy, rsp_valid, req_ready}); else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nr = 0; lowc = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (rsp_valid) nr++;
            if (!cs) lowc++;
        end
        n_checks++; if (nr !== 0)   $display("FAIL mid_no_rsp got %0d exp 0", nr); else n_pass++;
        n_checks++; if (lowc !== 0) $display("FAIL mid_cs_idle got %0d exp 0", lowc); else n_pass++;
        mem[7'h01] = 8'h00;
        issue(1'b0, 7'h01, 8'h99, 1'b0, k);
        observe(k, 300);
        n_checks++; if (rsp_rel !== 133)   $display("FAIL mid_after_rsp got %0d exp 133", rsp_rel); else n_pass++;
        n_checks++; if (ready_rel !== 137) $display("FAIL mid_after_ready got %0d exp 137", ready_rel); else n_pass++;
        n_checks++; if (mem[7'h01] !== 8'h99) $display("FAIL mid_after_mem got %h exp 99", mem[7'h01]); else n_pass++;
    endtask

    task automatic test_fast_div();
        int          k, rel, rises, r1, r2, rsp_at, rdy_at;
        logic        prev;
        logic [7:0]  data;
        logic [15:0] bits;
        @(negedge clk);
        req_valid_b = 1'b1; req_rw_b = 1'b1; req_addr_b = 7'h7F; req_wdata_b = 8'h3C;
        k = -1;
        for (int i = 0; i < 50 && k < 0; i++) begin
            if (req_ready_b) begin
                @(posedge clk);
                #1;
                k = cyc;
                req_valid_b = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        n_checks++; if (k < 0) $display("FAIL fast_accept got no accept exp accept"); else n_pass++;
        rises = 0; r1 = 0; r2 = 0; rsp_at = 0; rdy_at = 0; data = '0; bits = '0; prev = sclk_b;
        for (int i = 0; i < 200 && rdy_at == 0; i++) begin
            @(negedge clk);
            rel = cyc - k + 1;
            if (sclk_b && !prev) begin
                rises++;
                if (rises == 1) r1 = rel;
                if (rises == 2) r2 = rel;
                if (rises <= 16) bits = {bits[14:0], mosi_b};
            end
            prev = sclk_b;
            if (rsp_valid_b) begin rsp_at = rel; data = rsp_rdata_b; end
            if (req_ready_b) rdy_at = rel;
        end
        n_checks++; if (r1 !== 3)       $display("FAIL fast_first_rise got %0d exp 3", r1); else n_pass++;
        n_checks++; if (r2 - r1 !== 4)  $display("FAIL fast_sclk_period got %0d exp 4", r2 - r1); else n_pass++;
        n_checks++; if (rises !== 16)   $display("FAIL fast_rises got %0d exp 16", rises); else n_pass++;
        n_checks++; if (bits !== 16'hFF00) $display("FAIL fast_mosi got %h exp ff00", bits); else n_pass++;
        n_checks++; if (rsp_at !== 67)  $display("FAIL fast_rsp_cycle got %0d exp 67", rsp_at); else n_pass++;
        n_checks++; if (data !== 8'hFF) $display("FAIL fast_rdata got %h exp ff", data); else n_pass++;
        n_checks++; if (rdy_at !== 68)  $display("FAIL fast_ready_cycle got %0d exp 68", rdy_at); else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        test_reset();
        test_write_frame();
        test_read_frame();
        test_back_to_back();
        test_hold_fields();
        test_reset_mid_frame();
        test_fast_div();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Transaction sequencer that drives the SPI slave port (cs, sclk, mosi, miso) of our SPI data-memory peripheral from a parallel request/response interface.
- Serialises one 16-bit frame per request: 7-bit address, then the rw bit, then 8 data bits.
- Returns the read byte, or a completion pulse for writes.
- Sits between a local host/bus adapter and the SPI slave; it is the only master on the link.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 2..255.
- CS_GAP, 4, minimum clk cycles cs stays high between frames; legal range 1..255.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  controller can accept a request; high only in IDLE
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  7  target data-memory address
- req_wdata  in  8  write byte; ignored for reads
- rsp_valid  out  1  one-cycle pulse when the frame completes
- rsp_rdata  out  8  read byte; 0 for writes; held until the next rsp_valid
- busy  out  1  high from accept until return to IDLE
- cs  out  1  chip select to slave, active low, idles high
- sclk  out  1  serial clock, idles low (mode 0)
- mosi  out  1  master-out serial data
- miso  in  1  slave-out serial data, already synchronised upstream

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE; cs = 1, sclk = 0, mosi = 0.
  - req_ready = 1 after reset release; rsp_valid = 0, rsp_rdata = 0, busy = 0.
  - All counters = 0.
- Handshake: a request is accepted on a rising clk edge when req_valid & req_ready. The fields are latched into a 16-bit frame register {addr[6:0], rw, wdata[7:0]}. For reads, the data field is loaded as 0.
- Bit order: MSB first (a6..a0, rw, d7..d0). mosi changes only while sclk is low. The slave samples on rising sclk.
- States:
  - IDLE:
    - req_ready = 1.
    - On accept -> SETUP.
  - SETUP:
    - cs = 0, mosi = frame[15], for CLK_DIV cycles.
    - Then -> SHIFT with sclk rising.
  - SHIFT:
    - sclk toggles every CLK_DIV cycles.
    - On each rising edge: bit_cnt increments (0..15). For a read with bit_cnt >= 8, miso is shifted into the rx register, MSB first.
    - On each falling edge: the frame shifts left and mosi = new frame[15].
    - After the 16th rising edge and the following falling edge (sclk = 0) -> HOLD.
  - HOLD:
    - cs = 0, sclk = 0, mosi = 0, for CLK_DIV cycles.
    - Then cs = 1, rsp_valid pulses for 1 cycle, rsp_rdata = rx register (read) or 0 (write) -> GAP.
  - GAP:
    - cs = 1 for CS_GAP cycles.
    - Then -> IDLE.
- Latency, accept at cycle 0:
  - cs falls at cycle 1.
  - First rising sclk at 1+CLK_DIV.
  - cs rises and rsp_valid pulses at 1+33*CLK_DIV.
  - req_ready returns at 1+33*CLK_DIV+CS_GAP.
  - Defaults: 133 / 137.
- Counters:
  - div_cnt width is ceil(log2(CLK_DIV)); it counts down and reloads CLK_DIV-1 on each tick.
  - bit_cnt is 4 bits and must not wrap inside a frame; completion is detected on its 16th rising edge.
- Boundary conditions:
  - req_valid while busy is ignored. The host holds the request, and it is accepted in the first IDLE cycle.
  - Fields may change after the accept cycle with no effect.
  - Back-to-back requests are spaced by exactly CS_GAP idle cs-high cycles plus 1 IDLE cycle.
  - Reset mid-frame forces cs high immediately; no rsp_valid is produced for the aborted frame.
  - miso is ignored outside read data bits.
  - sclk never glitches: exactly 16 rising edges per frame.

Decomposition:
- Shared package spi_pkg holds:
  - SPI_ADDR_W = 7, SPI_DATA_W = 8, SPI_FRAME_W = 16.
  - Read/write bit encoding (READ = 1, WRITE = 0).
  - Controller state encoding (IDLE, SETUP, SHIFT, HOLD, GAP).
- One sub-module, spi_clk_div:
  - Half-period tick generator with enable and synchronous clear.
  - Outputs tick plus rise/fall qualifiers.
  - The controller instantiates it once.

Test Plan:
- Write addr 0x2A, data 0xC3, default params -> cs low for clk 1..132; mosi bits on rising sclk = 0101010_0_11000011; exactly 16 sclk rises; rsp_valid at cycle 133 with rsp_rdata = 0.
- Read addr 0x05 with slave model returning 0xA5 on miso bits 8..15 -> mosi = 0000101_1_00000000; rsp_rdata = 0xA5 on the rsp_valid pulse; busy low at cycle 137.
- Write 0x10/0x7E then read 0x10, against the slave + data-memory model -> read returns 0x7E; cs high for exactly CS_GAP+1 = 5 cycles between frames.
- req_valid held continuously with changing fields during a frame -> req_ready = 0 throughout; the second request is accepted only in IDLE; its latched fields equal the values present at the accept cycle.
- Assert rst_n low at the 9th rising sclk of a read -> cs = 1, sclk = 0, mosi = 0 asynchronously; no rsp_valid; after release, a fresh write completes normally.
- CLK_DIV = 2, CS_GAP = 1 -> sclk period 4 clks; rsp_valid at cycle 67; req_ready at 68.
